// File: rtl/m65c02_bus_cycle_ctrl.sv
// Memory-cycle sequencer: turns MMU wait-state requests and external Wait into core Rdy plus nOE/nWE strobes.
// Zero-wait accesses complete in the request cycle; a stuck Wait is aborted after pTO cycles with Bus_Err.
module m65c02_bus_cycle_ctrl #(
    parameter int pWS_Out = 3,
    parameter int pCntW   = 4,
    parameter int pTO     = 16
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [1:0]  IO_Op,
    input  logic [15:1] CE,
    input  logic        Int_WS,
    input  logic        Wait,
    input  logic        Err_Clr,
    output logic        Rdy,
    output logic        nOE,
    output logic        nWE,
    output logic        Busy,
    output logic        Bus_Err,
    output logic        Err_Flg
);

    localparam int TW = $clog2(pTO + 1);
    localparam logic [pCntW-1:0] WS_N    = pCntW'(pWS_Out);
    localparam logic [pCntW-1:0] CNT_ONE = pCntW'(1);
    localparam logic [TW-1:0]    TO_MAX  = TW'(pTO);
    localparam logic [TW-1:0]    TO_ONE  = TW'(1);

    typedef enum logic [1:0] {IDLE, CNT, EXTW} state_t;

    state_t            state, state_nxt;
    logic [pCntW-1:0]  cnt, cnt_nxt;
    logic [TW-1:0]     tocnt, tocnt_nxt;
    logic              req, ws_req, active, rdy, bus_err;

    assign req    = (IO_Op != 2'b00) && (CE != '0);
    assign ws_req = req && Int_WS && (WS_N != '0);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tocnt   <= '0;
            Err_Flg <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            tocnt <= tocnt_nxt;
            if (bus_err)
                Err_Flg <= 1'b1;
            else if (Err_Clr)
                Err_Flg <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tocnt_nxt = tocnt;
        rdy       = 1'b1;
        bus_err   = 1'b0;
        case (state)
            IDLE: begin
                if (ws_req) begin
                    rdy       = 1'b0;
                    cnt_nxt   = WS_N - CNT_ONE;
                    state_nxt = CNT;
                end else if (req && Wait) begin
                    rdy       = 1'b0;
                    tocnt_nxt = TO_ONE;
                    state_nxt = EXTW;
                end
            end
            CNT: begin
                if (cnt != '0) begin
                    rdy     = 1'b0;
                    cnt_nxt = cnt - CNT_ONE;
                end else if (Wait) begin
                    rdy       = 1'b0;
                    tocnt_nxt = TO_ONE;
                    state_nxt = EXTW;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXTW: begin
                if (!Wait) begin
                    state_nxt = IDLE;
                end else if (tocnt != TO_MAX) begin
                    rdy       = 1'b0;
                    tocnt_nxt = tocnt + TO_ONE;
                end else begin
                    // Forced completion: the core sees a ready cycle flagged as a bus error.
                    bus_err   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are gated by Rst so an aborted access releases the bus without waiting for an edge.
    assign active  = !Rst && ((state != IDLE) || req);
    assign nOE     = !(active && IO_Op[1] && (CE != '0));
    assign nWE     = !(active && (IO_Op == 2'b01) && (CE != '0) && !rdy);
    assign Rdy     = rdy;
    assign Busy    = (state != IDLE);
    assign Bus_Err = bus_err;

endmodule

// File: tb/tb_m65c02_bus_cycle_ctrl.sv
// Bench for m65c02_bus_cycle_ctrl: idle-cycle vector table, directed multi-cycle sequences, randomized accesses vs a model.
module tb_m65c02_bus_cycle_ctrl;

    localparam int WS = 3;
    localparam int TO = 16;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  IO_Op = 2'b00;
    logic [15:1] CE = '0;
    logic        Int_WS = 1'b0;
    logic        Wait = 1'b0;
    logic        Err_Clr = 1'b0;
    logic        Rdy, nOE, nWE, Busy, Bus_Err, Err_Flg;

    int checks = 0;
    int failures = 0;

    m65c02_bus_cycle_ctrl #(.pWS_Out(WS), .pCntW(4), .pTO(TO)) dut (
        .Clk(Clk), .Rst(Rst), .IO_Op(IO_Op), .CE(CE), .Int_WS(Int_WS), .Wait(Wait),
        .Err_Clr(Err_Clr), .Rdy(Rdy), .nOE(nOE), .nWE(nWE), .Busy(Busy),
        .Bus_Err(Bus_Err), .Err_Flg(Err_Flg)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  io;
        logic [15:1] ce;
        logic        iws;
        logic        wt;
        logic        rdy;
        logic        noe;
        logic        nwe;
    } vec_t;

    // One access with Wait taken from wpat[k] in access cycle k; returns per-access statistics.
    task automatic do_access(input logic [1:0] io, input logic [15:1] ce, input logic iws,
                             input logic [63:0] wpat, input logic clr,
                             output int low, output int oe_low, output int we_low, output int berr);
        int k;
        bit done;
        low = 0; oe_low = 0; we_low = 0; berr = 0; k = 0; done = 0;
        while (!done && k < 60) begin
            @(posedge Clk); #1;
            IO_Op = io; CE = ce; Int_WS = iws; Wait = wpat[k]; Err_Clr = clr;
            @(negedge Clk);
            if (!Rdy) low++;
            if (!nOE) oe_low++;
            if (!nWE) we_low++;
            if (Bus_Err) berr++;
            if (Rdy) done = 1;
            k++;
        end
        if (!done) chk("access_timeout_bound", 0, 1);
        @(posedge Clk); #1;
        IO_Op = 2'b00; Wait = 1'b0; Err_Clr = 1'b0;
    endtask

    initial begin
        vec_t vt[8];
        int low, oel, wel, be;
        logic [1:0] io;
        logic [15:1] ce;
        logic iws, w, clr, stuck, req, er, eb, eoe, ewe, err_m;
        int n, k, sel;
        bit done;

        vt[0] = '{2'd0, 15'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[1] = '{2'd2, 15'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{2'd3, 15'h4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[3] = '{2'd1, 15'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[4] = '{2'd2, 15'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[5] = '{2'd1, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[6] = '{2'd0, 15'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[7] = '{2'd3, 15'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_rdy", Rdy, 1);
        chk("rst_busy", Busy, 0);
        chk("rst_noe", nOE, 1);
        chk("rst_nwe", nWE, 1);
        chk("rst_buserr", Bus_Err, 0);
        chk("rst_errflg", Err_Flg, 0);
        @(posedge Clk); #1;
        Rst = 1'b0;

        // Idle-cycle vectors: each completes in one cycle and leaves the FSM in IDLE
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            IO_Op = vt[i].io; CE = vt[i].ce; Int_WS = vt[i].iws; Wait = vt[i].wt;
            @(negedge Clk);
            chk($sformatf("vec%0d_rdy", i), Rdy, vt[i].rdy);
            chk($sformatf("vec%0d_noe", i), nOE, vt[i].noe);
            chk($sformatf("vec%0d_nwe", i), nWE, vt[i].nwe);
            chk($sformatf("vec%0d_busy", i), Busy, 0);
            chk($sformatf("vec%0d_buserr", i), Bus_Err, 0);
            @(posedge Clk); #1;
            IO_Op = 2'b00; Wait = 1'b0;
            chk($sformatf("vec%0d_idle_after", i), Busy, 0);
        end

        // Reset asserted while counting wait states (Cnt=2)
        for (int j = 0; j < 2; j++) begin
            @(posedge Clk); #1;
            IO_Op = (j == 0) ? 2'd2 : 2'd1; CE = 15'h0002; Int_WS = 1'b1; Wait = 1'b0;
            @(posedge Clk); #1;
            chk("midrst_busy_before", Busy, 1);
            Rst = 1'b1;
            #1;
            chk("midrst_busy", Busy, 0);
            chk("midrst_noe", nOE, 1);
            chk("midrst_nwe", nWE, 1);
            IO_Op = 2'b00; Int_WS = 1'b0;
            @(posedge Clk); #1;
            Rst = 1'b0;
            @(negedge Clk);
            chk("midrst_rdy_after", Rdy, 1);
            chk("midrst_busy_after", Busy, 0);
        end

        do_access(2'd3, 15'h0002, 1'b1, 64'h0, 1'b0, low, oel, wel, be);
        chk("iws_read_rdy_low", low, WS);
        chk("iws_read_noe_low", oel, WS + 1);
        chk("iws_read_nwe_low", wel, 0);

        do_access(2'd1, 15'h0004, 1'b1, 64'h0, 1'b0, low, oel, wel, be);
        chk("iws_write_rdy_low", low, WS);
        chk("iws_write_nwe_low", wel, WS);
        chk("iws_write_noe_low", oel, 0);

        do_access(2'd2, 15'h0008, 1'b1, 64'h00F8, 1'b0, low, oel, wel, be);
        chk("extw_rdy_low", low, WS + 5);
        chk("extw_buserr", be, 0);
        chk("extw_errflg", Err_Flg, 0);

        do_access(2'd2, 15'h0001, 1'b0, {64{1'b1}}, 1'b0, low, oel, wel, be);
        chk("timeout_rdy_low", low, TO);
        chk("timeout_buserr_cycles", be, 1);
        chk("timeout_errflg", Err_Flg, 1);
        @(posedge Clk); #1;
        chk("timeout_errflg_sticky", Err_Flg, 1);
        Err_Clr = 1'b1;
        @(posedge Clk); #1;
        Err_Clr = 1'b0;
        chk("errclr_clears", Err_Flg, 0);

        do_access(2'd3, 15'h0100, 1'b1, {64{1'b1}}, 1'b1, low, oel, wel, be);
        chk("coinc_rdy_low", low, TO + WS);
        chk("coinc_buserr_cycles", be, 1);
        chk("coinc_errflg_set_wins", Err_Flg, 1);
        Err_Clr = 1'b1;
        @(posedge Clk); #1;
        Err_Clr = 1'b0;
        chk("coinc_errclr_after", Err_Flg, 0);
        err_m = 1'b0;

        // Randomized accesses against a per-access cycle-index model
        for (int a = 0; a < 250; a++) begin
            io  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            if (sel == 0)      ce = '0;
            else if (sel == 3) ce = 15'($urandom);
            else               ce = 15'(1) << $urandom_range(0, 14);
            iws   = 1'($urandom_range(0, 1));
            stuck = ($urandom_range(0, 6) == 0);
            req   = (io != 0) && (ce != 0);
            n     = (req && iws) ? WS : 0;
            k = 0; done = 0;
            while (!done) begin
                @(posedge Clk); #1;
                w   = stuck ? 1'b1 : 1'($urandom_range(0, 1));
                clr = ($urandom_range(0, 9) == 0);
                IO_Op = io; CE = ce; Int_WS = iws; Wait = w; Err_Clr = clr;
                if (!req)              begin er = 1; eb = 0; end
                else if (k < n)        begin er = 0; eb = 0; end
                else if (!w)           begin er = 1; eb = 0; end
                else if (k - n < TO)   begin er = 0; eb = 0; end
                else                   begin er = 1; eb = 1; end
                eoe = !(io >= 2 && ce != 0);
                ewe = !(io == 1 && ce != 0 && !er);
                @(negedge Clk);
                chk("rand_rdy", Rdy, er);
                chk("rand_noe", nOE, eoe);
                chk("rand_nwe", nWE, ewe);
                chk("rand_busy", Busy, (k > 0) ? 1 : 0);
                chk("rand_buserr", Bus_Err, eb);
                chk("rand_errflg", Err_Flg, err_m);
                err_m = eb ? 1'b1 : (clr ? 1'b0 : err_m);
                done = er;
                k++;
                if (k > 60) begin
                    chk("rand_access_bound", 0, 1);
                    done = 1;
                end
            end
        end
        @(posedge Clk); #1;
        Err_Clr = 1'b0;
        chk("rand_errflg_final", Err_Flg, err_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
